// File: rtl/multi_phase_traffic_controller_if.sv
// Purpose: signal bundle between the intersection sensor front-end and the
//          multi-phase traffic controller.
// Ports (modport slave = controller side):
//   demand         in  per-phase demand, level
//   emergency      in  preemption request, level
//   emerg_phase    in  phase to serve on preemption
//   lamps          out 3 bits per phase, RED=100 YELLOW=010 GREEN=001
//   phase          out currently served phase
//   state          out 00 GREEN, 01 YELLOW, 10 ALL_RED
//   remaining      out ticks left in the current interval
//   preempt_active out preemption sequence or hold in progress
interface multi_phase_traffic_controller_if #(
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned CNT_W      = 8
);
   localparam int unsigned PH_W = $clog2(NUM_PHASES);

   logic [NUM_PHASES-1:0]   demand;
   logic                    emergency;
   logic [PH_W-1:0]         emerg_phase;
   logic [3*NUM_PHASES-1:0] lamps;
   logic [PH_W-1:0]         phase;
   logic [1:0]              state;
   logic [CNT_W-1:0]        remaining;
   logic                    preempt_active;

   modport master (
      output demand, emergency, emerg_phase,
      input  lamps, phase, state, remaining, preempt_active
   );

   modport slave (
      input  demand, emergency, emerg_phase,
      output lamps, phase, state, remaining, preempt_active
   );
endinterface

// File: rtl/multi_phase_traffic_controller.sv
// Purpose: N-phase intersection controller. Each phase runs GREEN -> YELLOW ->
//          ALL_RED, then the next phase is chosen from emergency request and
//          demand. Supports phase skipping, bounded green extension and
//          emergency preemption. Timing counts ticks from an internal prescaler.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    controller side of multi_phase_traffic_controller_if (slave)
module multi_phase_traffic_controller #(
   parameter int unsigned NUM_PHASES   = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned TICK_DIV     = 50,
   parameter int unsigned GREEN_TIME   = 30,
   parameter int unsigned YELLOW_TIME  = 3,
   parameter int unsigned ALL_RED_TIME = 2,
   parameter int unsigned EXT_TIME     = 5,
   parameter int unsigned MAX_EXT      = 3
) (
   input logic                             clk,
   input logic                             rst_n,
   multi_phase_traffic_controller_if.slave bus
);
   localparam int unsigned PH_W   = $clog2(NUM_PHASES);
   localparam int unsigned LAMP_W = 3 * NUM_PHASES;

   typedef enum logic [1:0] {
      S_GREEN   = 2'b00,
      S_YELLOW  = 2'b01,
      S_ALL_RED = 2'b10
   } state_e;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   // Lamp heads for a given state/phase: only the served phase may be non-RED.
   function automatic logic [LAMP_W-1:0] lamp_pattern(state_e st, logic [PH_W-1:0] ph);
      logic [LAMP_W-1:0] l;
      l = '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         l[3*i +: 3] = LAMP_RED;
         if (st != S_ALL_RED && PH_W'(i) == ph) begin
            l[3*i +: 3] = (st == S_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
         end
      end
      return l;
   endfunction

   localparam logic [LAMP_W-1:0] LAMPS_RST = lamp_pattern(S_GREEN, PH_W'(0));

   state_e            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d, next_phase, cand;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0]  ext_q, ext_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic              preempt_q, preempt_d;
   logic [LAMP_W-1:0] lamps_q, lamps_d;
   logic              tick, emerg_ok, timer_done, extend_ok, found;

   // Next-phase selection at ALL_RED end; later rules override earlier ones
   // so the final assignment order gives emergency the highest priority.
   always_comb begin
      next_phase = PH_W'((32'(phase_q) + 32'd1) % NUM_PHASES);
      found      = 1'b0;
      cand       = '0;
      for (int unsigned k = 1; k < NUM_PHASES; k++) begin
         cand = PH_W'((32'(phase_q) + k) % NUM_PHASES);
         if (!found && bus.demand[cand]) begin
            next_phase = cand;
            found      = 1'b1;
         end
      end
      if (!found && bus.demand[phase_q]) next_phase = phase_q;
      if (emerg_ok) next_phase = bus.emerg_phase;
   end

   // Interval sequencing, extension and preemption.
   always_comb begin
      tick       = (presc_q == CNT_W'(TICK_DIV - 1));
      presc_d    = tick ? '0 : presc_q + CNT_W'(1);
      emerg_ok   = bus.emergency && (32'(bus.emerg_phase) < NUM_PHASES);
      timer_done = tick && (timer_q <= CNT_W'(1));
      extend_ok  = bus.demand[phase_q] && (ext_q < CNT_W'(MAX_EXT));
      state_d    = state_q;
      phase_d    = phase_q;
      timer_d    = timer_q;
      ext_d      = ext_q;
      preempt_d  = preempt_q;

      case (state_q)
         S_GREEN: begin
            if (emerg_ok) begin
               // Served phase requested: freeze timer; otherwise cut green now.
               preempt_d = 1'b1;
               if (bus.emerg_phase != phase_q) begin
                  state_d = S_YELLOW;
                  timer_d = CNT_W'(YELLOW_TIME);
               end
            end else begin
               preempt_d = 1'b0;
               if (timer_done) begin
                  if (extend_ok) begin
                     ext_d   = ext_q + CNT_W'(1);
                     timer_d = CNT_W'(EXT_TIME);
                  end else begin
                     state_d = S_YELLOW;
                     timer_d = CNT_W'(YELLOW_TIME);
                  end
               end else if (tick) begin
                  timer_d = timer_q - CNT_W'(1);
               end
            end
         end
         S_YELLOW: begin
            if (timer_done) begin
               state_d = S_ALL_RED;
               timer_d = CNT_W'(ALL_RED_TIME);
            end else if (tick) begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         S_ALL_RED: begin
            if (timer_done) begin
               state_d   = S_GREEN;
               phase_d   = next_phase;
               timer_d   = CNT_W'(GREEN_TIME);
               ext_d     = '0;
               preempt_d = emerg_ok;
            end else if (tick) begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         default: begin
            // Unreachable encoding: recover through a full clearance interval.
            state_d = S_ALL_RED;
            timer_d = CNT_W'(ALL_RED_TIME);
         end
      endcase

      lamps_d = lamp_pattern(state_d, phase_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_GREEN;
         phase_q   <= '0;
         timer_q   <= CNT_W'(GREEN_TIME);
         ext_q     <= '0;
         presc_q   <= '0;
         preempt_q <= 1'b0;
         lamps_q   <= LAMPS_RST;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         timer_q   <= timer_d;
         ext_q     <= ext_d;
         presc_q   <= presc_d;
         preempt_q <= preempt_d;
         lamps_q   <= lamps_d;
      end
   end

   assign bus.lamps          = lamps_q;
   assign bus.phase          = phase_q;
   assign bus.state          = state_q;
   assign bus.remaining      = timer_q;
   assign bus.preempt_active = preempt_q;
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Purpose: scoreboard bench for multi_phase_traffic_controller. A behavioural
//          model advances once per driven cycle and queues the outputs expected
//          after the next clock edge; a monitor pops and compares after each edge.
module tb_multi_phase_traffic_controller;
   localparam int N   = 3;
   localparam int TD  = 1;
   localparam int GT  = 4;
   localparam int YT  = 2;
   localparam int ART = 1;
   localparam int ET  = 2;
   localparam int MX  = 2;
   localparam int CW  = 8;

   localparam int ST_G = 0;
   localparam int ST_Y = 1;
   localparam int ST_R = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_phase_traffic_controller_if #(.NUM_PHASES(N), .CNT_W(CW)) bus ();

   multi_phase_traffic_controller #(
      .NUM_PHASES(N), .CNT_W(CW), .TICK_DIV(TD), .GREEN_TIME(GT),
      .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .EXT_TIME(ET), .MAX_EXT(MX)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      int lamps;
      int phase;
      int state;
      int rem;
      int pre;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: phase, interval kind, ticks left, extensions used.
   int m_state, m_phase, m_timer, m_ext, m_presc, m_pre;

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_state = ST_G; m_phase = 0; m_timer = GT; m_ext = 0; m_presc = 0; m_pre = 0;
   endtask

   function automatic int has_demand(int dem, int idx);
      return (dem >> idx) & 1;
   endfunction

   function automatic int pick_next(int dem, int ok, int ep);
      if (ok != 0) return ep;
      for (int k = 1; k < N; k++) begin
         if (has_demand(dem, (m_phase + k) % N) != 0) return (m_phase + k) % N;
      end
      if (has_demand(dem, m_phase) != 0) return m_phase;
      return (m_phase + 1) % N;
   endfunction

   // One clock of the intersection rules as seen from the road.
   task automatic model_step(int dem, int em, int ep);
      int ok;
      int tk;
      int ends;
      ok   = (em != 0 && ep < N) ? 1 : 0;
      tk   = (m_presc == TD - 1) ? 1 : 0;
      m_presc = (tk != 0) ? 0 : m_presc + 1;
      ends = (tk != 0 && m_timer == 1) ? 1 : 0;
      if (m_state == ST_G) begin
         if (ok != 0) begin
            m_pre = 1;
            if (ep != m_phase) begin m_state = ST_Y; m_timer = YT; end
         end else begin
            m_pre = 0;
            if (ends != 0 && has_demand(dem, m_phase) != 0 && m_ext < MX) begin
               m_ext++; m_timer = ET;
            end else if (ends != 0) begin
               m_state = ST_Y; m_timer = YT;
            end else if (tk != 0) begin
               m_timer--;
            end
         end
      end else if (ends != 0 && m_state == ST_Y) begin
         m_state = ST_R; m_timer = ART;
      end else if (ends != 0) begin
         m_phase = pick_next(dem, ok, ep);
         m_state = ST_G; m_timer = GT; m_ext = 0; m_pre = ok;
      end else if (tk != 0) begin
         m_timer--;
      end
   endtask

   function automatic int model_lamps();
      int l;
      int code;
      l = 0;
      for (int i = 0; i < N; i++) begin
         code = 4;
         if (i == m_phase && m_state == ST_G) code = 1;
         if (i == m_phase && m_state == ST_Y) code = 2;
         l = l | (code << (3 * i));
      end
      return l;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.lamps = model_lamps();
      e.phase = m_phase;
      e.state = m_state;
      e.rem   = m_timer;
      e.pre   = m_pre;
      exp_q.push_back(e);
   endtask

   task automatic cycle(int dem, int em, int ep);
      @(negedge clk);
      bus.demand      = 3'(dem);
      bus.emergency   = (em != 0);
      bus.emerg_phase = 2'(ep);
      model_step(dem, em, ep);
      push_exp();
   endtask

   // Idle with no demand until the model reaches a target (rem<0: any timer).
   task automatic run_until(int st, int ph, int rem, string name);
      int n;
      n = 0;
      while (!(m_state == st && m_phase == ph && (rem < 0 || m_timer == rem)) && n < 200) begin
         cycle(0, 0, 0);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s: target not reached within 200 cycles", name);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation after every edge.
   initial begin : monitor
      exp_t e;
      int nonred;
      int lv;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            lv = int'(bus.lamps);
            check("lamps", lv, e.lamps);
            check("phase", int'(bus.phase), e.phase);
            check("state", int'(bus.state), e.state);
            check("remaining", int'(bus.remaining), e.rem);
            check("preempt_active", int'(bus.preempt_active), e.pre);
            nonred = 0;
            for (int i = 0; i < N; i++) begin
               if (((lv >> (3 * i)) & 7) != 4) nonred++;
            end
            check("single_non_red", (nonred <= 1) ? 1 : 0, 1);
         end
      end
   end

   initial begin : stimulus
      int em;
      int ep;
      int dem;
      bus.demand      = '0;
      bus.emergency   = 1'b0;
      bus.emerg_phase = '0;
      rst_n           = 1'b0;
      model_reset();
      push_exp();
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Fixed-time cycle with no demand: 4,3,2,1,2,1,1,4 and phase 1 next.
      for (int i = 0; i < 8; i++) cycle(0, 0, 0);

      // Phase 1 skipped when only phase 2 has demand.
      run_until(ST_G, 0, -1, "reach_ph0_skip");
      for (int i = 0; i < 10; i++) cycle(3'b100, 0, 0);

      // Held demand on phase 0: two extensions then reserve green.
      run_until(ST_G, 0, -1, "reach_ph0_ext");
      for (int i = 0; i < 16; i++) cycle(3'b001, 0, 0);

      // Preemption to phase 2 from phase 0 green at remaining=3, then release.
      run_until(ST_G, 0, 3, "reach_ph0_rem3");
      for (int i = 0; i < 10; i++) cycle(0, 1, 2);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0);

      // Out-of-range emergency phase is ignored.
      for (int i = 0; i < 15; i++) cycle(0, 1, 3);

      // Randomised demand and emergency traffic.
      em = 0;
      ep = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            em = 1 - em;
            ep = int'($urandom_range(0, 3));
         end
         dem = int'($urandom_range(0, 7));
         cycle(dem, em, ep);
      end

      // Asynchronous reset in the middle of phase 1 yellow.
      run_until(ST_Y, 1, -1, "reach_ph1_yellow");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_lamps", int'(bus.lamps), model_lamps());
      check("async_rst_state", int'(bus.state), ST_G);
      check("async_rst_phase", int'(bus.phase), 0);
      check("async_rst_remaining", int'(bus.remaining), GT);
      check("async_rst_preempt", int'(bus.preempt_active), 0);
      bus.demand    = '0;
      bus.emergency = 1'b0;
      push_exp();
      @(negedge clk);
      rst_n = 1'b1;
      model_step(0, 0, 0);
      push_exp();
      for (int i = 0; i < 10; i++) cycle(0, 0, 0);

      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
